// File: rtl/cpu_oci_dct_ctrl.sv
// Nios II OCI DCT packing-buffer sequencer: packs 2-bit trace atoms into 15-slot packets.
// Optional idle auto-flush is enabled by defining DCT_TIMEOUT_EN.
module cpu_oci_dct_ctrl #(
    parameter int unsigned ATOM_W  = 2,
    parameter int unsigned SLOTS   = 15,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom_data,
    input  logic                      flush_req,
    input  logic                      test_ending,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [ATOM_W*SLOTS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    output logic                      test_has_ended,
    output logic [7:0]                overflow_cnt,
    output logic                      busy
);

    localparam int unsigned BUF_W = ATOM_W * SLOTS;
    localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

    typedef enum logic [2:0] {StIdle, StFill, StEmit, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         ovf_q, ovf_d;
    logic [BUF_W-1:0]   atom_wide;
    logic               accept;
    logic               drop;
    logic               flush;
    logic               timeout_hit;

    assign atom_wide = BUF_W'(atom_data);
    assign accept    = atom_valid & enable;
    assign flush     = flush_req | timeout_hit;

`ifdef DCT_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = '0;
        if (state_q == StFill && !accept) begin
            idle_d = idle_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == StFill) && (idle_q == IDLE_W'(TIMEOUT - 1)) && (cnt_q != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        drop    = 1'b0;
        unique case (state_q)
            StIdle, StFill: begin
                // Same-cycle atom is captured before any flush or drain decision.
                if (accept) begin
                    buf_d = buf_q | (atom_wide << (ATOM_W * cnt_q));
                    cnt_d = cnt_q + 1'b1;
                end
                if (test_ending) begin
                    state_d = (cnt_d == '0) ? StDone : StDrain;
                end else if (cnt_d == SLOTS_C || (flush && cnt_d != '0)) begin
                    state_d = StEmit;
                end else if (cnt_d != '0) begin
                    state_d = StFill;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    buf_d = '0;
                    cnt_d = '0;
                    if (test_ending) begin
                        drop    = accept;
                        state_d = StDone;
                    end else if (accept) begin
                        buf_d   = atom_wide;
                        cnt_d   = CNT_W'(1);
                        state_d = StFill;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    drop = accept;
                    if (test_ending) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                drop = accept;
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else if (out_ready) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (drop && ovf_q != 8'hff) begin
            ovf_d = ovf_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid      = (state_q == StEmit) || (state_q == StDrain && cnt_q != '0);
    assign busy           = (state_q == StEmit) || (state_q == StDrain);
    assign test_has_ended = (state_q == StDone);
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign overflow_cnt   = ovf_q;

endmodule
